clk_div_frac_multi: RTL
=======================

// Module: clk_div_frac_multi
// PURPOSE
//  Multi-channel programmable clock divider with fractional half-period dithering.
//  Each channel can run stand-alone or be cascaded from the previous channel.
//  Configuration is double-buffered: new values take effect only at a period boundary, so
//  reprogramming never produces a runt pulse. Sits beside the IO block and drives
//  peripheral baud/sample clocks and timer prescalers.
// PARAMETERS
//  CChCnt     4         number of divider channels (1..16)
//  CIntW      8         integer half-period field width
//  CFraW      4         fractional field width; dither accumulator width
//  CCascade   0         1: channel i>0 counts only on channel i-1 fall pulse; 0: all count on AClkHEn
//  CDivReset  {CIntW+CFraW{1'b0}}  config loaded into every channel at reset (0 = stopped)
// PORTS
//  AClkH      in   1                  single clock
//  AResetH    in   1                  asynchronous reset, active-high
//  AClkHEn    in   1                  clock enable; all state, including config writes, holds when 0
//  AWrEn      in   1                  config write strobe
//  AWrCh      in   $clog2(CChCnt)     channel index for write; index >= CChCnt is ignored
//  AWrData    in   CIntW+CFraW        {Int, Fra}: half period = Int + Fra/2^CFraW clocks
//  ACascadeI  in   1                  count qualifier for channel 0 when CCascade=1 (tie 1 if unused)
//  AClkOut    out  CChCnt             divided clocks, registered
//  ARise      out  CChCnt             one-cycle pulse, same cycle AClkOut[i] becomes 1
//  ACascadeO  out  1                  one-cycle pulse, same cycle AClkOut[CChCnt-1] becomes 0
// BEHAVIOUR
//  - Reset: every Shadow and Active register = CDivReset; Cnt=0; Acc=0; all outputs 0.
//    Outputs go to 0 immediately on AResetH, not at the next edge.
//  - Per-channel state: Shadow{Int,Fra}, Active{Int,Fra}, Cnt[CIntW], Acc[CFraW], Out.
//  - Write: at an edge with AClkHEn & AWrEn, Shadow[AWrCh] <= AWrData.
//  - Step enable: StepEn[i] = AClkHEn & Q[i].
//    - Q[0] = CCascade ? ACascadeI : 1.
//    - Q[i>0] = CCascade ? fall pulse of channel i-1 : 1.
//  - Stopped (Active.Int==0):
//    - Out, Cnt and Acc are held at 0.
//    - On any enabled edge, if Shadow != Active: Active <= Shadow, Cnt <= Shadow.Int-1, Acc <= 0.
//  - Running, on each StepEn edge:
//    - If Cnt != 0: Cnt <= Cnt-1.
//    - If Cnt == 0 (terminal): Out toggles; {Carry, Acc} <= Acc + Active.Fra; Cnt <= Active.Int-1+Carry.
//  - Period boundary = terminal edge with Out==1 (falling edge).
//    - At this edge Active <= Shadow, and the reload uses the NEW Int/Fra.
//    - Acc is cleared when Shadow != Active.
//    - If new Int==0: Out goes 0, channel stops.
//  - Rising terminal edges never apply Shadow; they always use the current Active.
//  - Latency: from the apply edge, the first rise occurs Int StepEn edges later.
//    Each high or low phase lasts Int or Int+1 StepEn edges.
//    Over 2^CFraW half periods, exactly Fra of them are long.
//  - Write in the same cycle as a falling terminal: that boundary uses the OLD Shadow.
//    The new value applies at the next boundary.
//  - Multiple writes before a boundary: the last write wins.
//  - Counter arithmetic: CIntW bits. Int-1+Carry never overflows because Int >= 1.
//  - ARise/ACascadeO: registered in the same edge as the Out change; never asserted while AClkHEn=0.
//  - CCascade=1: channel i>0 total division = product of the upstream full periods.
//    A stopped upstream channel freezes all downstream channels (their Out is held).
// TESTING
//  1. Ch0 write {Int=3,Fra=0} from reset -> first rise 4 clocks after write edge; then 3 high/3 low;
//     ARise every 6 clocks.
//  2. Ch0 {Int=2,Fra=8}, CFraW=4 -> half periods alternate 2,3; exactly 16 rises in 80 clocks.
//  3. CCascade=1: ch0 {1,0}, ch1 {2,0} -> ch1 period 8 clocks; ch1 ARise coincides with ch0 fall pulse.
//  4. Ch0 running {4,0}; write {1,0} while Out=1 -> current high phase completes at 4;
//     then 1 low/1 high; no phase <1 or >4.
//  5. Write {0,0} to running ch2 mid-high -> falls at normal boundary, then stays 0;
//     ARise silent; other channels unaffected.
//  6. AResetH pulsed mid-phase, AClkHEn toggled randomly -> outputs 0 immediately; config = CDivReset;
//     no state change while AClkHEn=0.

Source files
------------

// File: rtl/clk_div_frac_multi_if.sv
// Config-write bus and divided-clock outputs of clk_div_frac_multi.
interface clk_div_frac_multi_if #(
    parameter int CChCnt = 4,
    parameter int CIntW  = 8,
    parameter int CFraW  = 4
);
    localparam int CChW = (CChCnt > 1) ? $clog2(CChCnt) : 1;

    logic                   AClkHEn;
    logic                   AWrEn;
    logic [CChW-1:0]        AWrCh;
    logic [CIntW+CFraW-1:0] AWrData;
    logic                   ACascadeI;
    logic [CChCnt-1:0]      AClkOut;
    logic [CChCnt-1:0]      ARise;
    logic                   ACascadeO;

    modport master (
        output AClkHEn, AWrEn, AWrCh, AWrData, ACascadeI,
        input  AClkOut, ARise, ACascadeO
    );

    modport slave (
        input  AClkHEn, AWrEn, AWrCh, AWrData, ACascadeI,
        output AClkOut, ARise, ACascadeO
    );
endinterface

// File: rtl/clk_div_frac_multi.sv
// Multi-channel fractional clock divider with double-buffered config and optional cascading.
// Each channel dithers its half period between Int and Int+1 using a Fra accumulator.
module clk_div_frac_ch #(
    parameter int                     CIntW     = 8,
    parameter int                     CFraW     = 4,
    parameter logic [CIntW+CFraW-1:0] CDivReset = '0
) (
    input  logic                   AClkH,
    input  logic                   AResetH,
    input  logic                   clkEn,
    input  logic                   stepEn,
    input  logic                   wrEn,
    input  logic [CIntW+CFraW-1:0] wrData,
    output logic                   clkOut,
    output logic                   rise,
    output logic                   fallNow
);
    typedef struct packed {
        logic [CIntW-1:0] Int;
        logic [CFraW-1:0] Fra;
    } tCfg;

    tCfg              shadow, active, activeNxt;
    logic [CIntW-1:0] cnt, cntNxt, cntLoad, cntNext;
    logic [CFraW-1:0] acc, accNxt, accSum;
    logic             carry, outNxt, riseNxt;
    logic             running, pending;

    assign running  = (active.Int != '0);
    assign pending  = (shadow != active);
    assign fallNow  = stepEn & running & (cnt == '0) & clkOut;
    assign {carry, accSum} = {1'b0, acc} + {1'b0, active.Fra};
    assign cntLoad  = (shadow.Int == '0) ? '0 : shadow.Int - CIntW'(1);
    assign cntNext  = active.Int - CIntW'(1) + CIntW'(carry);

    always_comb begin
        activeNxt = active;
        cntNxt    = cnt;
        accNxt    = acc;
        outNxt    = clkOut;
        riseNxt   = 1'b0;
        if (!running) begin
            if (clkEn && pending) begin
                activeNxt = shadow;
                cntNxt    = cntLoad;
                accNxt    = '0;
            end
        end else if (stepEn) begin
            if (cnt != '0) begin
                cntNxt = cnt - CIntW'(1);
            end else if (!clkOut) begin
                // rising terminal: always keeps the current Active
                outNxt  = 1'b1;
                riseNxt = 1'b1;
                accNxt  = accSum;
                cntNxt  = cntNext;
            end else begin
                // period boundary: a changed config restarts the dither from zero
                outNxt    = 1'b0;
                activeNxt = shadow;
                if (pending) begin
                    accNxt = '0;
                    cntNxt = cntLoad;
                end else begin
                    accNxt = accSum;
                    cntNxt = cntNext;
                end
            end
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            shadow <= CDivReset;
            active <= CDivReset;
            cnt    <= '0;
            acc    <= '0;
            clkOut <= 1'b0;
            rise   <= 1'b0;
        end else begin
            if (wrEn) shadow <= wrData;
            active <= activeNxt;
            cnt    <= cntNxt;
            acc    <= accNxt;
            clkOut <= outNxt;
            rise   <= riseNxt;
        end
    end
endmodule

module clk_div_frac_multi #(
    parameter int                     CChCnt    = 4,
    parameter int                     CIntW     = 8,
    parameter int                     CFraW     = 4,
    parameter int                     CCascade  = 0,
    parameter logic [CIntW+CFraW-1:0] CDivReset = '0
) (
    input  logic                 AClkH,
    input  logic                 AResetH,
    clk_div_frac_multi_if.slave  ABus
);
    localparam int CChW = (CChCnt > 1) ? $clog2(CChCnt) : 1;

    logic [CChCnt-1:0] stepEn, fallNow, wrSel, clkOut, rise;
    logic              cascadeO;

    generate
        for (genvar i = 0; i < CChCnt; i++) begin : gCh
            // cascaded channels advance on the same edge their upstream neighbour falls
            if (i == 0) begin : gHead
                assign stepEn[i] = ABus.AClkHEn & ((CCascade != 0) ? ABus.ACascadeI : 1'b1);
            end else begin : gTail
                assign stepEn[i] = ABus.AClkHEn & ((CCascade != 0) ? fallNow[i-1] : 1'b1);
            end
            assign wrSel[i] = ABus.AClkHEn & ABus.AWrEn & (ABus.AWrCh == CChW'(i));

            clk_div_frac_ch #(
                .CIntW     (CIntW),
                .CFraW     (CFraW),
                .CDivReset (CDivReset)
            ) uCh (
                .AClkH   (AClkH),
                .AResetH (AResetH),
                .clkEn   (ABus.AClkHEn),
                .stepEn  (stepEn[i]),
                .wrEn    (wrSel[i]),
                .wrData  (ABus.AWrData),
                .clkOut  (clkOut[i]),
                .rise    (rise[i]),
                .fallNow (fallNow[i])
            );
        end
    endgenerate

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) cascadeO <= 1'b0;
        else         cascadeO <= fallNow[CChCnt-1];
    end

    assign ABus.AClkOut   = clkOut;
    assign ABus.ARise     = rise;
    assign ABus.ACascadeO = cascadeO;
endmodule
